wb_sad_track_stage: RTL and testbench

WB_SAD_TRACK_STAGE -- requirements
Module: wb_sad_track_stage

---
 rtl/wb_sad_track_stage_if.sv | 42 ++++
 rtl/wb_sad_track_stage.sv | 170 +++++++++++++++++
 tb/tb_wb_sad_track_stage.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/wb_sad_track_stage_if.sv
// Writeback/SAD-tracking stage bus: MEM/SAD beat inputs and registered writeback, Hi/Lo and tracker outputs.
interface wb_sad_track_stage_if #(
  parameter int unsigned COUNT_W = 16
);
  logic               iValid;
  logic               RegWrite2WB;
  logic               Move;
  logic               Zero;
  logic [2:0]         MemToReg;
  logic [4:0]         RegDstResult;
  logic [31:0]        PCPlus4;
  logic [31:0]        ALUResult;
  logic [31:0]        MemReadData;
  logic [31:0]        Sum;
  logic [63:0]        HiLoResult;
  logic               HiLoWrite;
  logic               SADClear;

  logic               oValid;
  logic               oRegWrite;
  logic [4:0]         oWriteReg;
  logic [31:0]        oWriteData;
  logic [31:0]        oHi;
  logic [31:0]        oLo;
  logic [31:0]        oMinSum;
  logic [COUNT_W-1:0] oMinIndex;
  logic [COUNT_W-1:0] oSumCount;

  modport master (
    output iValid, RegWrite2WB, Move, Zero, MemToReg, RegDstResult,
           PCPlus4, ALUResult, MemReadData, Sum, HiLoResult, HiLoWrite, SADClear,
    input  oValid, oRegWrite, oWriteReg, oWriteData, oHi, oLo,
           oMinSum, oMinIndex, oSumCount
  );

  modport slave (
    input  iValid, RegWrite2WB, Move, Zero, MemToReg, RegDstResult,
           PCPlus4, ALUResult, MemReadData, Sum, HiLoResult, HiLoWrite, SADClear,
    output oValid, oRegWrite, oWriteReg, oWriteData, oHi, oLo,
           oMinSum, oMinIndex, oSumCount
  );
endinterface

// File: rtl/wb_sad_track_stage.sv
// Writeback stage with Hi/Lo registers and a best-match SAD tracker.
// The tracker is built only when WB_SAD_TRACK_EN is defined; otherwise its outputs are constant.
module wb_sad_track_stage #(
  parameter int unsigned COUNT_W = 16
) (
  input logic                  Clk,
  input logic                  Reset,
  wb_sad_track_stage_if.slave  bus
);

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned REG_W    = 5;
  localparam logic [DATA_W-1:0] MIN_INIT = 32'hFFFF_FFFF;

  localparam logic [2:0] SEL_ALU = 3'b000;
  localparam logic [2:0] SEL_MEM = 3'b001;
  localparam logic [2:0] SEL_PC4 = 3'b010;
  localparam logic [2:0] SEL_HI  = 3'b011;
  localparam logic [2:0] SEL_LO  = 3'b100;
  localparam logic [2:0] SEL_SUM = 3'b101;

  logic              valid_q,      valid_d;
  logic              reg_write_q,  reg_write_d;
  logic [REG_W-1:0]  write_reg_q,  write_reg_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [DATA_W-1:0] hi_q,         hi_d;
  logic [DATA_W-1:0] lo_q,         lo_d;

  logic              hilo_load_c;
  logic [DATA_W-1:0] hi_byp_c;
  logic [DATA_W-1:0] lo_byp_c;
  logic [DATA_W-1:0] wb_data_c;

  // Hi/Lo reads see a same-beat Hi/Lo update rather than the stale register.
  always_comb begin
    hilo_load_c = bus.iValid & bus.HiLoWrite;
    hi_byp_c    = hilo_load_c ? bus.HiLoResult[63:32] : hi_q;
    lo_byp_c    = hilo_load_c ? bus.HiLoResult[31:0]  : lo_q;
    case (bus.MemToReg)
      SEL_ALU: wb_data_c = bus.ALUResult;
      SEL_MEM: wb_data_c = bus.MemReadData;
      SEL_PC4: wb_data_c = bus.PCPlus4;
      SEL_HI:  wb_data_c = hi_byp_c;
      SEL_LO:  wb_data_c = lo_byp_c;
      SEL_SUM: wb_data_c = bus.Sum;
      default: wb_data_c = bus.ALUResult;
    endcase
  end

  // Writeback next state: address/data hold on idle cycles, Move gates the write on Zero.
  always_comb begin
    valid_d      = bus.iValid;
    reg_write_d  = bus.iValid & bus.RegWrite2WB & (~bus.Move | bus.Zero)
                   & (bus.RegDstResult != REG_W'(0));
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    if (bus.iValid) begin
      write_reg_d  = bus.RegDstResult;
      write_data_d = wb_data_c;
    end
    if (hilo_load_c) begin
      hi_d = bus.HiLoResult[63:32];
      lo_d = bus.HiLoResult[31:0];
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      valid_q      <= 1'b0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      hi_q         <= '0;
      lo_q         <= '0;
    end else begin
      valid_q      <= valid_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
    end
  end

  assign bus.oValid     = valid_q;
  assign bus.oRegWrite  = reg_write_q;
  assign bus.oWriteReg  = write_reg_q;
  assign bus.oWriteData = write_data_q;
  assign bus.oHi        = hi_q;
  assign bus.oLo        = lo_q;

`ifdef WB_SAD_TRACK_EN
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_TRACK = 1'b1
  } trk_state_e;

  trk_state_e         state_q,   state_d;
  logic [DATA_W-1:0]  min_sum_q, min_sum_d;
  logic [COUNT_W-1:0] min_idx_q, min_idx_d;
  logic [COUNT_W-1:0] sum_cnt_q, sum_cnt_d;

  logic               sad_beat_c;
  logic               base_empty_c;
  logic [DATA_W-1:0]  base_min_c;
  logic [COUNT_W-1:0] base_cnt_c;

  // Clear resolves first so a simultaneous SAD beat becomes the first result.
  always_comb begin
    state_d      = state_q;
    min_sum_d    = min_sum_q;
    min_idx_d    = min_idx_q;
    sum_cnt_d    = sum_cnt_q;
    sad_beat_c   = bus.iValid & (bus.MemToReg == SEL_SUM);
    base_empty_c = (state_q == ST_EMPTY);
    base_min_c   = min_sum_q;
    base_cnt_c   = sum_cnt_q;

    if (bus.SADClear) begin
      state_d      = ST_EMPTY;
      min_sum_d    = MIN_INIT;
      min_idx_d    = '0;
      sum_cnt_d    = '0;
      base_empty_c = 1'b1;
      base_min_c   = MIN_INIT;
      base_cnt_c   = '0;
    end

    // A saturated count is already all-ones, so it doubles as the saturated index.
    if (sad_beat_c) begin
      state_d   = ST_TRACK;
      sum_cnt_d = (base_cnt_c == CNT_MAX) ? CNT_MAX : base_cnt_c + COUNT_W'(1);
      if (base_empty_c || (bus.Sum < base_min_c)) begin
        min_sum_d = bus.Sum;
        min_idx_d = base_cnt_c;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= ST_EMPTY;
      min_sum_q <= MIN_INIT;
      min_idx_q <= '0;
      sum_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      min_sum_q <= min_sum_d;
      min_idx_q <= min_idx_d;
      sum_cnt_q <= sum_cnt_d;
    end
  end

  assign bus.oMinSum   = min_sum_q;
  assign bus.oMinIndex = min_idx_q;
  assign bus.oSumCount = sum_cnt_q;
`else
  logic unused_sad_clear_c;

  assign unused_sad_clear_c = bus.SADClear;
  assign bus.oMinSum        = MIN_INIT;
  assign bus.oMinIndex      = '0;
  assign bus.oSumCount      = '0;
`endif

endmodule

// File: tb/tb_wb_sad_track_stage.sv
// Directed bench for wb_sad_track_stage; a second 3-bit-count instance shares the stimulus to reach saturation.
module tb_wb_sad_track_stage;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  wb_sad_track_stage_if #(.COUNT_W(16)) bus ();
  wb_sad_track_stage_if #(.COUNT_W(3))  bus2 ();

  wb_sad_track_stage #(.COUNT_W(16)) dut  (.Clk(clk), .Reset(rst_n), .bus(bus));
  wb_sad_track_stage #(.COUNT_W(3))  dut2 (.Clk(clk), .Reset(rst_n), .bus(bus2));

  assign bus2.iValid       = bus.iValid;
  assign bus2.RegWrite2WB  = bus.RegWrite2WB;
  assign bus2.Move         = bus.Move;
  assign bus2.Zero         = bus.Zero;
  assign bus2.MemToReg     = bus.MemToReg;
  assign bus2.RegDstResult = bus.RegDstResult;
  assign bus2.PCPlus4      = bus.PCPlus4;
  assign bus2.ALUResult    = bus.ALUResult;
  assign bus2.MemReadData  = bus.MemReadData;
  assign bus2.Sum          = bus.Sum;
  assign bus2.HiLoResult   = bus.HiLoResult;
  assign bus2.HiLoWrite    = bus.HiLoWrite;
  assign bus2.SADClear     = bus.SADClear;

`ifdef WB_SAD_TRACK_EN
  localparam bit TRK = 1'b1;
`else
  localparam bit TRK = 1'b0;
`endif

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.iValid       = 1'b0;
    bus.RegWrite2WB  = 1'b0;
    bus.Move         = 1'b0;
    bus.Zero         = 1'b0;
    bus.MemToReg     = 3'd0;
    bus.RegDstResult = 5'd0;
    bus.PCPlus4      = 32'd0;
    bus.ALUResult    = 32'd0;
    bus.MemReadData  = 32'd0;
    bus.Sum          = 32'd0;
    bus.HiLoResult   = 64'd0;
    bus.HiLoWrite    = 1'b0;
    bus.SADClear     = 1'b0;
  endtask

  task automatic sad_beat(input logic [31:0] s, input logic clr);
    idle();
    bus.iValid   = 1'b1;
    bus.MemToReg = 3'b101;
    bus.Sum      = s;
    bus.SADClear = clr;
    tick();
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_valid"}, 64'(bus.oValid), 64'd0);
    chk({pfx, "_regwrite"}, 64'(bus.oRegWrite), 64'd0);
    chk({pfx, "_wreg"}, 64'(bus.oWriteReg), 64'd0);
    chk({pfx, "_wdata"}, 64'(bus.oWriteData), 64'd0);
    chk({pfx, "_hi"}, 64'(bus.oHi), 64'd0);
    chk({pfx, "_lo"}, 64'(bus.oLo), 64'd0);
    chk({pfx, "_minsum"}, 64'(bus.oMinSum), 64'hFFFF_FFFF);
    chk({pfx, "_minidx"}, 64'(bus.oMinIndex), 64'd0);
    chk({pfx, "_cnt"}, 64'(bus.oSumCount), 64'd0);
  endtask

  initial begin
    idle();
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Memory load writeback
    idle();
    bus.iValid = 1'b1; bus.RegWrite2WB = 1'b1; bus.MemToReg = 3'b001;
    bus.MemReadData = 32'h1234_5678; bus.RegDstResult = 5'd8;
    tick();
    chk("ld_valid", 64'(bus.oValid), 64'd1);
    chk("ld_regwrite", 64'(bus.oRegWrite), 64'd1);
    chk("ld_wreg", 64'(bus.oWriteReg), 64'd8);
    chk("ld_wdata", 64'(bus.oWriteData), 64'h1234_5678);

    // Idle cycle holds address/data
    idle();
    tick();
    chk("idle_valid", 64'(bus.oValid), 64'd0);
    chk("idle_regwrite", 64'(bus.oRegWrite), 64'd0);
    chk("idle_wreg", 64'(bus.oWriteReg), 64'd8);
    chk("idle_wdata", 64'(bus.oWriteData), 64'h1234_5678);

    // Conditional move
    idle();
    bus.iValid = 1'b1; bus.RegWrite2WB = 1'b1; bus.Move = 1'b1; bus.Zero = 1'b0;
    bus.ALUResult = 32'h11; bus.RegDstResult = 5'd9;
    tick();
    chk("movz0_regwrite", 64'(bus.oRegWrite), 64'd0);
    chk("movz0_wreg", 64'(bus.oWriteReg), 64'd9);
    chk("movz0_wdata", 64'(bus.oWriteData), 64'h11);
    bus.Zero = 1'b1;
    tick();
    chk("movz1_regwrite", 64'(bus.oRegWrite), 64'd1);
    bus.RegDstResult = 5'd0;
    tick();
    chk("r0_z1_regwrite", 64'(bus.oRegWrite), 64'd0);
    chk("r0_z1_valid", 64'(bus.oValid), 64'd1);
    bus.Zero = 1'b0;
    tick();
    chk("r0_z0_regwrite", 64'(bus.oRegWrite), 64'd0);

    // Hi/Lo write with same-beat bypass
    idle();
    bus.iValid = 1'b1; bus.RegWrite2WB = 1'b1; bus.RegDstResult = 5'd3;
    bus.HiLoWrite = 1'b1; bus.HiLoResult = 64'hAAAA_0000_0000_5555; bus.MemToReg = 3'b011;
    tick();
    chk("byp_hi_wdata", 64'(bus.oWriteData), 64'hAAAA_0000);
    chk("hilo_hi", 64'(bus.oHi), 64'hAAAA_0000);
    chk("hilo_lo", 64'(bus.oLo), 64'h0000_5555);
    idle();
    bus.HiLoWrite = 1'b1; bus.HiLoResult = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    chk("hilo_noval_hi", 64'(bus.oHi), 64'hAAAA_0000);
    chk("hilo_noval_wdata", 64'(bus.oWriteData), 64'hAAAA_0000);
    idle();
    bus.iValid = 1'b1; bus.MemToReg = 3'b100;
    tick();
    chk("lo_reg_wdata", 64'(bus.oWriteData), 64'h0000_5555);
    bus.HiLoWrite = 1'b1; bus.HiLoResult = 64'h0123_4567_89AB_CDEF;
    tick();
    chk("byp_lo_wdata", 64'(bus.oWriteData), 64'h89AB_CDEF);
    chk("hilo2_hi", 64'(bus.oHi), 64'h0123_4567);
    idle();
    bus.iValid = 1'b1; bus.MemToReg = 3'b010; bus.PCPlus4 = 32'h400;
    tick();
    chk("pc4_wdata", 64'(bus.oWriteData), 64'h400);
    bus.MemToReg = 3'b111; bus.ALUResult = 32'h77;
    tick();
    chk("sel7_wdata", 64'(bus.oWriteData), 64'h77);
    chk("nosad_cnt", 64'(bus.oSumCount), 64'd0);

    // SAD tracking with a tie
    sad_beat(32'd50, 1'b0);
    sad_beat(32'd20, 1'b0);
    sad_beat(32'd20, 1'b0);
    sad_beat(32'd70, 1'b0);
    chk("sad_wdata", 64'(bus.oWriteData), 64'd70);
    chk("sad4_min", 64'(bus.oMinSum), TRK ? 64'd20 : 64'hFFFF_FFFF);
    chk("sad4_idx", 64'(bus.oMinIndex), TRK ? 64'd1 : 64'd0);
    chk("sad4_cnt", 64'(bus.oSumCount), TRK ? 64'd4 : 64'd0);

    // Clear together with a SAD beat
    sad_beat(32'd90, 1'b1);
    chk("clr_min", 64'(bus.oMinSum), TRK ? 64'd90 : 64'hFFFF_FFFF);
    chk("clr_idx", 64'(bus.oMinIndex), 64'd0);
    chk("clr_cnt", 64'(bus.oSumCount), TRK ? 64'd1 : 64'd0);
    sad_beat(32'd100, 1'b0);
    sad_beat(32'd90, 1'b0);
    chk("tie_min", 64'(bus.oMinSum), TRK ? 64'd90 : 64'hFFFF_FFFF);
    chk("tie_idx", 64'(bus.oMinIndex), 64'd0);
    chk("tie_cnt", 64'(bus.oSumCount), TRK ? 64'd3 : 64'd0);

    // Count saturation (3-bit instance saturates at 7)
    sad_beat(32'd500, 1'b1);
    sad_beat(32'd400, 1'b0);
    for (int i = 0; i < 5; i++) sad_beat(32'd450, 1'b0);
    chk("sat_cnt_at7", 64'(bus2.oSumCount), TRK ? 64'd7 : 64'd0);
    chk("sat_idx_pre", 64'(bus2.oMinIndex), TRK ? 64'd1 : 64'd0);
    sad_beat(32'd300, 1'b0);
    sad_beat(32'd200, 1'b0);
    chk("sat_cnt", 64'(bus2.oSumCount), TRK ? 64'd7 : 64'd0);
    chk("sat_idx", 64'(bus2.oMinIndex), TRK ? 64'd7 : 64'd0);
    chk("sat_min", 64'(bus2.oMinSum), TRK ? 64'd200 : 64'hFFFF_FFFF);
    chk("wide_cnt", 64'(bus.oSumCount), TRK ? 64'd9 : 64'd0);
    chk("wide_idx", 64'(bus.oMinIndex), TRK ? 64'd8 : 64'd0);

    // Asynchronous reset mid-stream
    idle();
    bus.iValid = 1'b1; bus.MemToReg = 3'b101; bus.Sum = 32'd5;
    bus.RegWrite2WB = 1'b1; bus.RegDstResult = 5'd4;
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("mid");
    @(posedge clk);
    #1 chk("rst_hold_valid", 64'(bus.oValid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.Sum = 32'd33;
    tick();
    chk("fresh_valid", 64'(bus.oValid), 64'd1);
    chk("fresh_regwrite", 64'(bus.oRegWrite), 64'd1);
    chk("fresh_wreg", 64'(bus.oWriteReg), 64'd4);
    chk("fresh_wdata", 64'(bus.oWriteData), 64'd33);
    chk("fresh_min", 64'(bus.oMinSum), TRK ? 64'd33 : 64'hFFFF_FFFF);
    chk("fresh_idx", 64'(bus.oMinIndex), 64'd0);
    chk("fresh_cnt", 64'(bus.oSumCount), TRK ? 64'd1 : 64'd0);

    idle();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
